// File: rtl/ws2812b_receiver.sv
// ws2812b_receiver
// Decodes a WS2812B single-wire pixel stream into 24-bit pixels.
// The receiver locks onto the line only after a full reset-low period.
// A high pulse of at least T_BIT_THRESH cycles decodes as a 1; a shorter
// legal pulse decodes as a 0. Bits are placed LSb-first at positions
// 0..23, so byte 0 of the stream lands in pixel_o[7:0].
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   din_i          asynchronous serial data line
//   pixel_o        last complete pixel; holds between pulses
//   pixel_valid_o  one-cycle pulse: pixel_o / pixel_idx_o are new
//   pixel_idx_o    0-based index of pixel_o within the current frame
//   frame_done_o   one-cycle pulse at the end of a frame
//   err_o          one-cycle pulse on a protocol violation
//
// state | meaning
// ------+----------------------------------------------------------
// SYNC  | not locked; waiting for RESET_CYCLES of continuous low
// LOW   | line low between bits; a long low ends the frame
// HIGH  | measuring the length of a high pulse
module ws2812b_receiver #(
    parameter int unsigned NUM_LED      = 768,
    parameter int unsigned RESET_CYCLES = 5000,
    parameter int unsigned T_HIGH_MIN   = 20,
    parameter int unsigned T_BIT_THRESH = 60,
    parameter int unsigned T_HIGH_MAX   = 110
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        din_i,
    output logic [23:0] pixel_o,
    output logic        pixel_valid_o,
    output logic [9:0]  pixel_idx_o,
    output logic        frame_done_o,
    output logic        err_o
);

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    localparam logic [15:0] RST_LIM = 16'(RESET_CYCLES);
    localparam logic [15:0] HI_MIN  = 16'(T_HIGH_MIN);
    localparam logic [15:0] HI_THR  = 16'(T_BIT_THRESH);
    localparam logic [15:0] HI_MAX  = 16'(T_HIGH_MAX);
    localparam logic [10:0] PX_LIM  = 11'(NUM_LED);

    logic        s1, s2, s3;
    logic        rise, fall;
    logic [1:0]  state;
    logic [15:0] low_cnt;
    logic [15:0] hi_cnt;
    logic [15:0] bit_cnt;
    logic [10:0] frame_px;
    logic [23:0] shift_q;
    logic        bit_val;
    logic [23:0] word_next;

    assign rise    = !s3 && s2;
    assign fall    = s3 && !s2;
    assign bit_val = (hi_cnt >= HI_THR);

    // Overwrite the slot at bit_cnt so stale bits from a discarded partial
    // pixel never leak into the next one.
    assign word_next = (shift_q & ~(24'd1 << bit_cnt)) | (24'(bit_val) << bit_cnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            s3            <= 1'b0;
            state         <= ST_SYNC;
            low_cnt       <= '0;
            hi_cnt        <= '0;
            bit_cnt       <= '0;
            frame_px      <= '0;
            shift_q       <= '0;
            pixel_o       <= '0;
            pixel_idx_o   <= '0;
            pixel_valid_o <= 1'b0;
            frame_done_o  <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            s1            <= din_i;
            s2            <= s1;
            s3            <= s2;
            pixel_valid_o <= 1'b0;
            frame_done_o  <= 1'b0;
            err_o         <= 1'b0;

            case (state)
                ST_SYNC: begin
                    if (s2) begin
                        low_cnt <= '0;
                    end else if (low_cnt >= RST_LIM - 16'd1) begin
                        low_cnt <= RST_LIM;
                        state   <= ST_LOW;
                    end else begin
                        low_cnt <= low_cnt + 16'd1;
                    end
                end

                ST_LOW: begin
                    if (rise) begin
                        state   <= ST_HIGH;
                        hi_cnt  <= 16'd1;
                        low_cnt <= '0;
                    end else if (!s2 && (low_cnt < RST_LIM)) begin
                        low_cnt <= low_cnt + 16'd1;
                        if ((low_cnt == RST_LIM - 16'd1) &&
                            ((bit_cnt != 16'd0) || (frame_px != 11'd0))) begin
                            frame_done_o <= 1'b1;
                            err_o        <= (bit_cnt != 16'd0);
                            bit_cnt      <= '0;
                            frame_px     <= '0;
                        end
                    end
                end

                ST_HIGH: begin
                    if (s2) begin
                        // Comparing before the increment flags the pulse on
                        // the sample that would push it past T_HIGH_MAX.
                        if (hi_cnt >= HI_MAX) begin
                            err_o    <= 1'b1;
                            bit_cnt  <= '0;
                            frame_px <= '0;
                            low_cnt  <= '0;
                            state    <= ST_SYNC;
                        end else begin
                            hi_cnt <= hi_cnt + 16'd1;
                        end
                    end else if (fall) begin
                        if (hi_cnt < HI_MIN) begin
                            err_o    <= 1'b1;
                            bit_cnt  <= '0;
                            frame_px <= '0;
                            low_cnt  <= 16'd1;
                            state    <= ST_SYNC;
                        end else begin
                            state   <= ST_LOW;
                            low_cnt <= 16'd1;
                            shift_q <= word_next;
                            if (bit_cnt == 16'd23) begin
                                bit_cnt <= '0;
                                if (frame_px < PX_LIM) begin
                                    pixel_o       <= word_next;
                                    pixel_idx_o   <= frame_px[9:0];
                                    pixel_valid_o <= 1'b1;
                                    frame_px      <= frame_px + 11'd1;
                                end else begin
                                    err_o <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 16'd1;
                            end
                        end
                    end
                end

                default: state <= ST_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_receiver.sv
// tb_ws2812b_receiver
// Drives random and directed WS2812B pulse trains into two receivers
// (NUM_LED=768 and NUM_LED=2) sharing one data line, and compares their
// pixel, error and frame-done events against a pulse-level model.
module tb_ws2812b_receiver;

    localparam int RST_CYC = 5000;
    localparam int T_MIN   = 20;
    localparam int T_THR   = 60;
    localparam int T_MAX   = 110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;

    logic [23:0] px_a, px_b;
    logic        pv_a, pv_b;
    logic [9:0]  idx_a, idx_b;
    logic        fd_a, fd_b;
    logic        err_a, err_b;

    always #5 clk = ~clk;

    ws2812b_receiver #(
        .NUM_LED(768), .RESET_CYCLES(RST_CYC), .T_HIGH_MIN(T_MIN),
        .T_BIT_THRESH(T_THR), .T_HIGH_MAX(T_MAX)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst), .din_i(din),
        .pixel_o(px_a), .pixel_valid_o(pv_a), .pixel_idx_o(idx_a),
        .frame_done_o(fd_a), .err_o(err_a)
    );

    ws2812b_receiver #(
        .NUM_LED(2), .RESET_CYCLES(RST_CYC), .T_HIGH_MIN(T_MIN),
        .T_BIT_THRESH(T_THR), .T_HIGH_MAX(T_MAX)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .din_i(din),
        .pixel_o(px_b), .pixel_valid_o(pv_b), .pixel_idx_o(idx_b),
        .frame_done_o(fd_b), .err_o(err_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- observed events (written only by the monitor) ----
    logic [23:0] obs_px_a [64];
    int          obs_idx_a[64];
    int          obs_cyc_a[64];
    logic [23:0] obs_px_b [64];
    int          obs_idx_b[64];
    int          obs_n_a = 0;
    int          obs_n_b = 0;
    int          obs_err[2];
    int          obs_fd[2];
    int          obs_both[2];
    int          obs_excl = 0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            obs_err[i]  = 0;
            obs_fd[i]   = 0;
            obs_both[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (pv_a && obs_n_a < 64) begin
                obs_px_a[obs_n_a]  = px_a;
                obs_idx_a[obs_n_a] = int'(idx_a);
                obs_cyc_a[obs_n_a] = cyc;
                obs_n_a++;
            end
            if (pv_b && obs_n_b < 64) begin
                obs_px_b[obs_n_b]  = px_b;
                obs_idx_b[obs_n_b] = int'(idx_b);
                obs_n_b++;
            end
            if (err_a) obs_err[0]++;
            if (err_b) obs_err[1]++;
            if (fd_a) obs_fd[0]++;
            if (fd_b) obs_fd[1]++;
            if (err_a && fd_a) obs_both[0]++;
            if (err_b && fd_b) obs_both[1]++;
            if (pv_a && (err_a || fd_a)) obs_excl++;
            if (pv_b && (err_b || fd_b)) obs_excl++;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (pulse level) ----------------
    bit          m_sync = 1'b0;
    int          m_low = 0;
    int          m_nbits = 0;
    logic [23:0] m_word = '0;
    int          m_px[2];
    int          nled[2];
    logic [23:0] m_last_px[2];
    int          m_last_idx[2];

    logic [23:0] exp_px_a[$];
    int          exp_idx_a[$];
    int          exp_cyc_a[$];
    logic [23:0] exp_px_b[$];
    int          exp_idx_b[$];
    int          exp_err[2];
    int          exp_fd[2];
    int          exp_both[2];
    int          rd_a = 0;
    int          rd_b = 0;
    int          base_err[2];
    int          base_fd[2];
    int          base_both[2];

    task automatic model_reset();
        m_sync  = 1'b0;
        m_low   = 0;
        m_nbits = 0;
        for (int i = 0; i < 2; i++) begin
            m_px[i]       = 0;
            m_last_px[i]  = '0;
            m_last_idx[i] = 0;
        end
    endtask

    // hi: pulse length in cycles; fe: clock edge at which the falling edge
    // is first sampled (pixel_valid is expected two edges later).
    task automatic model_pulse(input int hi, input int fe);
        m_low = 0;
        if (!m_sync) return;
        if (hi < T_MIN || hi > T_MAX) begin
            for (int i = 0; i < 2; i++) begin
                exp_err[i]++;
                m_px[i] = 0;
            end
            m_nbits = 0;
            m_sync  = 1'b0;
            return;
        end
        m_word[m_nbits] = (hi >= T_THR);
        m_nbits++;
        if (m_nbits == 24) begin
            m_nbits = 0;
            for (int i = 0; i < 2; i++) begin
                if (m_px[i] < nled[i]) begin
                    if (i == 0) begin
                        exp_px_a.push_back(m_word);
                        exp_idx_a.push_back(m_px[i]);
                        exp_cyc_a.push_back(fe + 2);
                    end else begin
                        exp_px_b.push_back(m_word);
                        exp_idx_b.push_back(m_px[i]);
                    end
                    m_last_px[i]  = m_word;
                    m_last_idx[i] = m_px[i];
                    m_px[i]++;
                end else begin
                    exp_err[i]++;
                end
            end
        end
    endtask

    task automatic model_low(input int n);
        int old;
        old   = m_low;
        m_low = m_low + n;
        if (old < RST_CYC && m_low >= RST_CYC) begin
            if (!m_sync) begin
                m_sync = 1'b1;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (m_nbits != 0 || m_px[i] != 0) begin
                        exp_fd[i]++;
                        if (m_nbits != 0) begin
                            exp_err[i]++;
                            exp_both[i]++;
                        end
                    end
                    m_px[i] = 0;
                end
                m_nbits = 0;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    // All drive tasks start and end on a falling clock edge.
    task automatic send_pulse(input int hi, input int lo);
        int fe;
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        fe  = cyc + 1;
        model_pulse(hi, fe);
        repeat (lo) @(negedge clk);
        model_low(lo);
    endtask

    task automatic send_low(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
        model_low(n);
    endtask

    task automatic send_pixel(input logic [23:0] p);
        int hi, lo;
        for (int i = 0; i < 24; i++) begin
            hi = p[i] ? int'($urandom_range(T_MAX, T_THR)) : int'($urandom_range(T_THR - 1, T_MIN));
            lo = int'($urandom_range(40, 1));
            send_pulse(hi, lo);
        end
    endtask

    task automatic send_pixel_std(input logic [23:0] p);
        for (int i = 0; i < 24; i++) begin
            if (p[i]) send_pulse(80, 45);
            else      send_pulse(40, 85);
        end
    endtask

    task automatic compare_events(input string tag);
        #1;
        check_val({tag, ":npix_a"}, obs_n_a - rd_a, exp_px_a.size());
        while (rd_a < obs_n_a && exp_px_a.size() > 0) begin
            check_val({tag, ":data_a"}, obs_px_a[rd_a], exp_px_a.pop_front());
            check_val({tag, ":idx_a"}, obs_idx_a[rd_a], exp_idx_a.pop_front());
            check_val({tag, ":lat_a"}, obs_cyc_a[rd_a], exp_cyc_a.pop_front());
            rd_a++;
        end
        rd_a = obs_n_a;
        exp_px_a.delete();
        exp_idx_a.delete();
        exp_cyc_a.delete();

        check_val({tag, ":npix_b"}, obs_n_b - rd_b, exp_px_b.size());
        while (rd_b < obs_n_b && exp_px_b.size() > 0) begin
            check_val({tag, ":data_b"}, obs_px_b[rd_b], exp_px_b.pop_front());
            check_val({tag, ":idx_b"}, obs_idx_b[rd_b], exp_idx_b.pop_front());
            rd_b++;
        end
        rd_b = obs_n_b;
        exp_px_b.delete();
        exp_idx_b.delete();

        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("%s:err_%0d", tag, i), obs_err[i] - base_err[i], exp_err[i]);
            check_val($sformatf("%s:fdone_%0d", tag, i), obs_fd[i] - base_fd[i], exp_fd[i]);
            check_val($sformatf("%s:err_and_fdone_%0d", tag, i), obs_both[i] - base_both[i], exp_both[i]);
            base_err[i]  = obs_err[i];
            base_fd[i]   = obs_fd[i];
            base_both[i] = obs_both[i];
            exp_err[i]   = 0;
            exp_fd[i]    = 0;
            exp_both[i]  = 0;
        end
        check_val({tag, ":pulse_overlap"}, obs_excl, 0);
        check_val({tag, ":hold_px_a"}, px_a, m_last_px[0]);
        check_val({tag, ":hold_idx_a"}, idx_a, m_last_idx[0]);
        check_val({tag, ":hold_px_b"}, px_b, m_last_px[1]);
        check_val({tag, ":hold_idx_b"}, idx_b, m_last_idx[1]);
        @(negedge clk);
        model_low(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ":px_a"}, px_a, 0);
        check_val({tag, ":idx_a"}, idx_a, 0);
        check_val({tag, ":px_b"}, px_b, 0);
        check_val({tag, ":pulses"}, {pv_a, fd_a, err_a, pv_b, fd_b, err_b}, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [23:0] p;
        int          bound_hi[4];

        nled[0] = 768;
        nled[1] = 2;
        for (int i = 0; i < 2; i++) begin
            exp_err[i]   = 0;
            exp_fd[i]    = 0;
            exp_both[i]  = 0;
            base_err[i]  = 0;
            base_fd[i]   = 0;
            base_both[i] = 0;
        end
        model_reset();
        bound_hi[0] = 59;
        bound_hi[1] = 60;
        bound_hi[2] = 110;
        bound_hi[3] = 20;

        rst = 1'b1;
        din = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        send_low(RST_CYC + 10);
        compare_events("sync");

        send_pixel_std(24'h0000FF);
        send_low(RST_CYC + 10);
        compare_events("single_px");

        send_pixel(24'h123456);
        send_pixel(24'hABCDEF);
        send_pixel(24'hFFFFFF);
        send_low(RST_CYC + 10);
        compare_events("three_px");

        for (int i = 0; i < 12; i++)
            send_pulse(int'($urandom_range(T_MAX, T_MIN)), int'($urandom_range(40, 1)));
        send_low(RST_CYC + 10);
        compare_events("partial_frame");

        for (int f = 0; f < 2; f++) begin
            n = int'($urandom_range(2, 1));
            for (int k = 0; k < n; k++) begin
                p = 24'($urandom());
                send_pixel(p);
            end
            send_low(RST_CYC + 10);
            compare_events($sformatf("rand_frame%0d", f));
        end

        for (int i = 0; i < 24; i++)
            send_pulse(bound_hi[i % 4], int'($urandom_range(40, 1)));
        send_low(RST_CYC + 10);
        check_val("bound_len:value", px_a, 24'h666666);
        compare_events("bound_len");

        send_pulse(111, 30);
        compare_events("high_111");
        send_low(RST_CYC + 10);
        compare_events("resync_111");

        send_pulse(10, 30);
        p = 24'($urandom());
        send_pixel(p);
        send_low(RST_CYC + 10);
        compare_events("short_pulse");
        p = 24'($urandom());
        send_pixel(p);
        send_low(RST_CYC + 10);
        compare_events("after_resync");

        for (int i = 0; i < 6; i++)
            send_pulse(int'($urandom_range(T_MAX, T_MIN)), int'($urandom_range(40, 1)));
        compare_events("pre_reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("mid_reset");
        model_reset();
        rst = 1'b0;
        send_low(RST_CYC + 10);
        p = 24'($urandom());
        send_pixel(p);
        send_low(20);
        compare_events("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812b_receiver.md
WS2812B_RECEIVER -- requirements
Module: ws2812b_receiver

Interface
REQ-001 Parameter NUM_LED, default 768: maximum pixels accepted per frame.
REQ-002 Parameter RESET_CYCLES, default 5000: continuous-low clk_i cycles that mark a frame reset (50 us at 100 MHz).
REQ-003 Parameter T_HIGH_MIN, default 20: minimum legal high-pulse length in cycles.
REQ-004 Parameter T_BIT_THRESH, default 60: high pulses of at least this many cycles decode as 1; shorter pulses decode as 0.
REQ-005 Parameter T_HIGH_MAX, default 110: maximum legal high-pulse length in cycles.
REQ-006 clk_i  input  1  100 MHz clock; all logic on the rising edge.
REQ-007 rst_i  input  1  reset; one clock; reset is synchronous and active-high.
REQ-008 din_i  input  1  asynchronous WS2812B serial data line.
REQ-009 pixel_o  output  24  last complete pixel; byte 0 in [7:0], byte 1 in [15:8], byte 2 in [23:16].
REQ-010 pixel_valid_o  output  1  one-cycle pulse; pixel_o and pixel_idx_o are new.
REQ-011 pixel_idx_o  output  10  0-based index of pixel_o within the current frame.
REQ-012 frame_done_o  output  1  one-cycle pulse at the end of a frame.
REQ-013 err_o  output  1  one-cycle pulse on a protocol violation.

Function
REQ-014 din_i SHALL pass through a 2-flop synchronizer (s1, s2) plus one history flop (s3); rise = !s3 & s2, fall = s3 & !s2.
REQ-015 FSM states: SYNC, LOW, HIGH; rst_i forces SYNC.
REQ-016 SYNC: low_cnt counts consecutive cycles with s2=0 and clears when s2=1; at low_cnt == RESET_CYCLES, go to LOW with low_cnt saturated; emit no frame_done_o and no err_o.
REQ-017 LOW: low_cnt increments while s2=0 and saturates at RESET_CYCLES.
REQ-018 LOW, rise: go to HIGH with hi_cnt=1 and low_cnt=0.
REQ-019 LOW, low_cnt reaching RESET_CYCLES with bit_cnt != 0 or frame_px != 0: frame_done_o pulses once; bit_cnt and frame_px clear.
REQ-020 Same event with bit_cnt != 0: err_o also pulses; the partial pixel is discarded.
REQ-021 HIGH: hi_cnt increments each cycle with s2=1; hi_cnt > T_HIGH_MAX gives err_o, clears bit_cnt and frame_px, and goes to SYNC.
REQ-022 HIGH, fall with hi_cnt < T_HIGH_MIN: err_o, clear bit_cnt and frame_px, go to SYNC.
REQ-023 HIGH, legal fall: bit = (hi_cnt >= T_BIT_THRESH); go to LOW with low_cnt=1.
REQ-024 Decoded bit SHALL be written at shift position bit_cnt (LSb of each byte first, bytes in arrival order); bit_cnt increments, range 0..23.
REQ-025 On the 24th bit with frame_px < NUM_LED: pixel_o and pixel_idx_o=frame_px load, pixel_valid_o pulses, frame_px increments, bit_cnt returns to 0.
REQ-026 On the 24th bit with frame_px == NUM_LED: the pixel is dropped, err_o pulses, frame_px holds, bit_cnt returns to 0.
REQ-027 Latency: pixel_valid_o is high during the cycle following the 2nd rising clk_i edge after the edge at which din_i is first sampled low at the 24th bit's falling edge.
REQ-028 Gaps shorter than RESET_CYCLES between bits SHALL be accepted with no error; there is no minimum low time.
REQ-029 All counters are 16-bit and unsigned; frame_px is 11-bit so it can hold NUM_LED.
REQ-030 pixel_o and pixel_idx_o SHALL hold between pulses.
REQ-031 err_o, frame_done_o and pixel_valid_o SHALL be mutually exclusive except at a REQ-019/REQ-020 partial-frame end, where err_o and frame_done_o pulse together.

Reset
REQ-032 While rst_i=1 at a clock edge: state=SYNC, all counters 0, pixel_o=0, pixel_idx_o=0, all pulse outputs 0, s1/s2/s3=0.
REQ-033 rst_i asserted mid-pixel SHALL discard the partial data; after release, decoding resumes only after RESET_CYCLES of continuous low.

Verification
REQ-034 Release reset; hold low 5000 cycles; send 24 bits of 0x0000FF (bit 1 = 80 high/45 low, bit 0 = 40 high/85 low); hold low 5000 -> one pixel_valid_o with pixel_o=0x0000FF, pixel_idx_o=0, then one frame_done_o, no err_o.
REQ-035 After sync, send 3 pixels 0x123456, 0xABCDEF, 0xFFFFFF back-to-back, then reset-low -> pixel_idx_o 0,1,2 with matching data; frame_done_o exactly once.
REQ-036 After sync, send a 10-cycle high pulse -> err_o once, FSM in SYNC; a following valid frame is ignored until 5000 low cycles, then decodes correctly.
REQ-037 After sync, send 12 valid bits, then low 5000 -> err_o and frame_done_o in the same cycle, no pixel_valid_o; the next frame starts at pixel_idx_o=0.
REQ-038 NUM_LED=2; send 3 pixels -> two pixel_valid_o pulses (idx 0,1); third pixel dropped with one err_o.
REQ-039 Boundary bit lengths: high=59 decodes 0, high=60 decodes 1, high=110 is legal, high=111 gives err_o.
